// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: control bundle, operands and instruction fields, with a saturating bubble counter.
// Optional macro ID_EX_SRC_FWD_EN adds registered source-register numbers for EX forwarding.
module id_ex_stage_reg #(
    parameter int unsigned BUB_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 freeze,
    input  logic                 flush,
    input  logic                 bubble_in,
    input  logic                 wb_en_in,
    input  logic                 mem_r_en_in,
    input  logic                 mem_w_en_in,
    input  logic                 b_in,
    input  logic                 s_in,
    input  logic [3:0]           exe_cmd_in,
    input  logic [31:0]          pc_in,
    input  logic [31:0]          val_rn_in,
    input  logic [31:0]          val_rm_in,
    input  logic                 imm_in,
    input  logic [11:0]          shift_operand_in,
    input  logic [23:0]          signed_imm_24_in,
    input  logic [3:0]           dest_in,
    input  logic [3:0]           status_in,
`ifdef ID_EX_SRC_FWD_EN
    input  logic [3:0]           src1_in,
    input  logic [3:0]           src2_in,
    output logic [3:0]           src1_out,
    output logic [3:0]           src2_out,
`endif
    output logic                 wb_en_out,
    output logic                 mem_r_en_out,
    output logic                 mem_w_en_out,
    output logic                 b_out,
    output logic                 s_out,
    output logic [3:0]           exe_cmd_out,
    output logic [31:0]          pc_out,
    output logic [31:0]          val_rn_out,
    output logic [31:0]          val_rm_out,
    output logic                 imm_out,
    output logic [11:0]          shift_operand_out,
    output logic [23:0]          signed_imm_24_out,
    output logic [3:0]           dest_out,
    output logic [3:0]           status_out,
    output logic                 valid_out,
    output logic [BUB_CNT_W-1:0] bubble_count
);

    logic empty_slot;
    assign empty_slot = flush | bubble_in;

    // Control bundle: cleared on an empty slot, since a flush comes from EX independently of the ID select.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en_out    <= 1'b0;
            mem_r_en_out <= 1'b0;
            mem_w_en_out <= 1'b0;
            b_out        <= 1'b0;
            s_out        <= 1'b0;
            exe_cmd_out  <= '0;
            valid_out    <= 1'b0;
            bubble_count <= '0;
        end else if (!freeze) begin
            if (empty_slot) begin
                wb_en_out    <= 1'b0;
                mem_r_en_out <= 1'b0;
                mem_w_en_out <= 1'b0;
                b_out        <= 1'b0;
                s_out        <= 1'b0;
                exe_cmd_out  <= '0;
                valid_out    <= 1'b0;
                if (bubble_count != '1)
                    bubble_count <= bubble_count + BUB_CNT_W'(1);
            end else begin
                wb_en_out    <= wb_en_in;
                mem_r_en_out <= mem_r_en_in;
                mem_w_en_out <= mem_w_en_in;
                b_out        <= b_in;
                s_out        <= s_in;
                exe_cmd_out  <= exe_cmd_in;
                valid_out    <= 1'b1;
            end
        end
    end

    // Data fields load regardless of flush/bubble; EX ignores them when valid_out is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_out            <= '0;
            val_rn_out        <= '0;
            val_rm_out        <= '0;
            imm_out           <= 1'b0;
            shift_operand_out <= '0;
            signed_imm_24_out <= '0;
            dest_out          <= '0;
            status_out        <= '0;
        end else if (!freeze) begin
            pc_out            <= pc_in;
            val_rn_out        <= val_rn_in;
            val_rm_out        <= val_rm_in;
            imm_out           <= imm_in;
            shift_operand_out <= shift_operand_in;
            signed_imm_24_out <= signed_imm_24_in;
            dest_out          <= dest_in;
            status_out        <= status_in;
        end
    end

`ifdef ID_EX_SRC_FWD_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src1_out <= '0;
            src2_out <= '0;
        end else if (!freeze) begin
            src1_out <= src1_in;
            src2_out <= src2_in;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed vector table, corner sequences and a randomized run
// against a behavioural model of the per-edge priority rules.
module tb_id_ex_stage_reg;

    localparam int unsigned W = 4;
    localparam int CNT_MAX = (1 << W) - 1;

    typedef struct packed {
        logic        wb_en;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        b;
        logic        s;
        logic [3:0]  exe_cmd;
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic        imm;
        logic [11:0] shift_operand;
        logic [23:0] signed_imm_24;
        logic [3:0]  dest;
        logic [3:0]  status;
        logic [3:0]  src1;
        logic [3:0]  src2;
    } bundle_t;

    typedef struct {
        logic        frz, fl, bub;
        logic        wb, mw;
        logic [3:0]  exe;
        logic [31:0] pc;
        logic        e_wb, e_mw;
        logic [3:0]  e_exe;
        logic [31:0] e_pc;
        logic        e_valid;
        int          e_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic freeze = 1'b0, flush = 1'b0, bubble_in = 1'b0;
    bundle_t din = '0;

    logic        wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out, valid_out;
    logic [3:0]  exe_cmd_out, dest_out, status_out;
    logic [31:0] pc_out, val_rn_out, val_rm_out;
    logic [11:0] shift_operand_out;
    logic [23:0] signed_imm_24_out;
    logic [W-1:0] bubble_count;
`ifdef ID_EX_SRC_FWD_EN
    logic [3:0]  src1_out, src2_out;
`endif

    // Reference model state
    bundle_t exp_q;
    logic    exp_valid;
    int      exp_cnt;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.BUB_CNT_W(W)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .bubble_in(bubble_in),
        .wb_en_in(din.wb_en), .mem_r_en_in(din.mem_r_en), .mem_w_en_in(din.mem_w_en),
        .b_in(din.b), .s_in(din.s), .exe_cmd_in(din.exe_cmd), .pc_in(din.pc),
        .val_rn_in(din.val_rn), .val_rm_in(din.val_rm), .imm_in(din.imm),
        .shift_operand_in(din.shift_operand), .signed_imm_24_in(din.signed_imm_24),
        .dest_in(din.dest), .status_in(din.status),
`ifdef ID_EX_SRC_FWD_EN
        .src1_in(din.src1), .src2_in(din.src2), .src1_out(src1_out), .src2_out(src2_out),
`endif
        .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
        .b_out(b_out), .s_out(s_out), .exe_cmd_out(exe_cmd_out), .pc_out(pc_out),
        .val_rn_out(val_rn_out), .val_rm_out(val_rm_out), .imm_out(imm_out),
        .shift_operand_out(shift_operand_out), .signed_imm_24_out(signed_imm_24_out),
        .dest_out(dest_out), .status_out(status_out), .valid_out(valid_out),
        .bubble_count(bubble_count)
    );

    function automatic bundle_t get_out();
        bundle_t o;
        o = '0;
        o.wb_en = wb_en_out; o.mem_r_en = mem_r_en_out; o.mem_w_en = mem_w_en_out;
        o.b = b_out; o.s = s_out; o.exe_cmd = exe_cmd_out; o.pc = pc_out;
        o.val_rn = val_rn_out; o.val_rm = val_rm_out; o.imm = imm_out;
        o.shift_operand = shift_operand_out; o.signed_imm_24 = signed_imm_24_out;
        o.dest = dest_out; o.status = status_out;
`ifdef ID_EX_SRC_FWD_EN
        o.src1 = src1_out; o.src2 = src2_out;
`endif
        return o;
    endfunction

    function automatic bundle_t rand_bundle();
        bundle_t r;
        r.wb_en = 1'($urandom()); r.mem_r_en = 1'($urandom()); r.mem_w_en = 1'($urandom());
        r.b = 1'($urandom()); r.s = 1'($urandom()); r.exe_cmd = 4'($urandom());
        r.pc = $urandom(); r.val_rn = $urandom(); r.val_rm = $urandom();
        r.imm = 1'($urandom()); r.shift_operand = 12'($urandom());
        r.signed_imm_24 = 24'($urandom()); r.dest = 4'($urandom());
        r.status = 4'($urandom()); r.src1 = 4'($urandom()); r.src2 = 4'($urandom());
        return r;
    endfunction

    task automatic model_reset();
        exp_q = '0; exp_valid = 1'b0; exp_cnt = 0;
    endtask

    // One clock edge of the specified behaviour, evaluated on the currently driven inputs.
    task automatic model_edge();
        if (freeze) return;
        exp_q = din;
`ifndef ID_EX_SRC_FWD_EN
        exp_q.src1 = '0; exp_q.src2 = '0;
`endif
        if (flush || bubble_in) begin
            exp_q.wb_en = 0; exp_q.mem_r_en = 0; exp_q.mem_w_en = 0;
            exp_q.b = 0; exp_q.s = 0; exp_q.exe_cmd = '0;
            exp_valid = 1'b0;
            exp_cnt = (exp_cnt < CNT_MAX) ? exp_cnt + 1 : CNT_MAX;
        end else begin
            exp_valid = 1'b1;
        end
    endtask

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %0h want %0h (t=%0t)", nm, got, want, $time);
    endtask

    task automatic check_all(input string tag);
        chk({tag, " fields"}, 256'(get_out()), 256'(exp_q));
        chk({tag, " valid"}, 256'(valid_out), 256'(exp_valid));
        chk({tag, " count"}, 256'(bubble_count), 256'(exp_cnt));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        #3;
        rst = 1'b1;
    endtask

    vec_t vt[8];

    initial begin
        int cnt_before;
        bundle_t held;
        logic held_valid;

        vt[0] = '{0,0,0, 1,0,4'h2,32'h10, 1,0,4'h2,32'h10, 1,0};
        vt[1] = '{0,1,1, 1,1,4'h2,32'h20, 0,0,4'h0,32'h20, 0,1};
        vt[2] = '{0,0,1, 1,1,4'h7,32'h30, 0,0,4'h0,32'h30, 0,2};
        vt[3] = '{0,0,0, 0,1,4'hF,32'h40, 0,1,4'hF,32'h40, 1,2};
        vt[4] = '{0,1,0, 1,0,4'h3,32'h50, 0,0,4'h0,32'h50, 0,3};
        vt[5] = '{1,1,1, 1,1,4'h9,32'h60, 0,0,4'h0,32'h50, 0,3};
        vt[6] = '{1,0,0, 1,1,4'h9,32'h70, 0,0,4'h0,32'h50, 0,3};
        vt[7] = '{0,0,0, 1,1,4'h9,32'h80, 1,1,4'h9,32'h80, 1,3};

        // Power-on reset, released away from the clock edge
        model_reset();
        @(posedge clk); #2;
        check_all("por");
        rst = 1'b1;
        #1;

        // Asynchronous reset with all-ones inputs, then recovery with no extra empty cycle
        din = '1;
        step();
        check_all("ones load");
        do_reset();
        #1;
        step();
        check_all("post reset");
        chk("post reset valid", 256'(valid_out), 256'(1));

        // Directed vector table from a fresh reset
        @(negedge clk);
        do_reset();
        foreach (vt[i]) begin
            din = rand_bundle();
            freeze = vt[i].frz; flush = vt[i].fl; bubble_in = vt[i].bub;
            din.wb_en = vt[i].wb; din.mem_w_en = vt[i].mw;
            din.exe_cmd = vt[i].exe; din.pc = vt[i].pc;
            if (i == 0) din.dest = 4'd5;
            step();
            chk($sformatf("vec%0d wb", i), 256'(wb_en_out), 256'(vt[i].e_wb));
            chk($sformatf("vec%0d mw", i), 256'(mem_w_en_out), 256'(vt[i].e_mw));
            chk($sformatf("vec%0d exe", i), 256'(exe_cmd_out), 256'(vt[i].e_exe));
            chk($sformatf("vec%0d pc", i), 256'(pc_out), 256'(vt[i].e_pc));
            chk($sformatf("vec%0d valid", i), 256'(valid_out), 256'(vt[i].e_valid));
            chk($sformatf("vec%0d count", i), 256'(bubble_count), 256'(vt[i].e_cnt));
            if (i == 0) chk("vec0 dest", 256'(dest_out), 256'(5));
            check_all($sformatf("vec%0d", i));
        end

        // Three-edge freeze with flush raised on the second edge and held until freeze drops
        freeze = 0; flush = 0; bubble_in = 0;
        din = rand_bundle(); din.wb_en = 1; din.exe_cmd = 4'h6;
        step();
        held = get_out(); held_valid = valid_out; cnt_before = exp_cnt;
        for (int k = 0; k < 3; k++) begin
            din = rand_bundle();
            freeze = 1; flush = (k >= 1);
            step();
            chk($sformatf("freeze%0d hold", k), 256'(get_out()), 256'(exp_q));
            chk($sformatf("freeze%0d valid", k), 256'(valid_out), 256'(1));
            chk($sformatf("freeze%0d count", k), 256'(bubble_count), 256'(cnt_before));
        end
        freeze = 0; din = rand_bundle(); din.wb_en = 1; din.exe_cmd = 4'hA;
        step();
        chk("unfreeze flush wb", 256'(wb_en_out), 256'(0));
        chk("unfreeze flush exe", 256'(exe_cmd_out), 256'(0));
        chk("unfreeze flush valid", 256'(valid_out), 256'(0));
        chk("unfreeze flush count", 256'(bubble_count), 256'(cnt_before + 1));
        check_all("unfreeze");
        flush = 0;

`ifdef ID_EX_SRC_FWD_EN
        din = rand_bundle(); din.src1 = 4'd3; din.src2 = 4'd7;
        step();
        chk("src1", 256'(src1_out), 256'(3));
        chk("src2", 256'(src2_out), 256'(7));
        din.src1 = 4'd9; din.src2 = 4'd1; bubble_in = 1;
        step();
        chk("src1 bubble", 256'(src1_out), 256'(9));
        chk("src2 bubble", 256'(src2_out), 256'(1));
        bubble_in = 0;
        @(negedge clk);
        do_reset();
        chk("src1 reset", 256'(src1_out), 256'(0));
`endif

        // Saturation: 17 consecutive bubbles from reset
        @(negedge clk);
        do_reset();
        bubble_in = 1;
        for (int k = 1; k <= 17; k++) begin
            din = rand_bundle();
            step();
            if (k >= 15) chk($sformatf("sat edge%0d", k), 256'(bubble_count), 256'(15));
        end
        check_all("sat");
        bubble_in = 0;

        // Randomized run against the model, with occasional mid-stream asynchronous resets
        for (int n = 0; n < 400; n++) begin
            din = rand_bundle();
            freeze    = ($urandom_range(0, 99) < 20);
            flush     = ($urandom_range(0, 99) < 20);
            bubble_in = ($urandom_range(0, 99) < 20);
            step();
            check_all($sformatf("rand%0d", n));
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
                check_all("rand reset");
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

ID/EX pipeline register of the five-stage ARM core with cache. It captures the decoded control bundle (write-back, memory, branch, status-update enables and the 4-bit execute command) together with the operand and instruction fields produced by the ID stage, and presents them to the EX stage one cycle later. It holds its contents while the cache stalls the pipeline and clears them on a taken branch or a hazard bubble. A saturating counter reports how many empty slots were inserted.

## Interface
Parameters:
- `BUB_CNT_W`, default 16: width of the bubble counter.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `freeze`  in  1  cache not ready; hold every register
- `flush`  in  1  branch taken in EX; squash the ID instruction
- `bubble_in`  in  1  hazard unit select (same signal that zeroes the control unit outputs); insert a bubble
- `wb_en_in`, `mem_r_en_in`, `mem_w_en_in`, `b_in`, `s_in`  in  1 each  control bundle from ID
- `exe_cmd_in`  in  4  ALU command
- `pc_in`, `val_rn_in`, `val_rm_in`  in  32 each  PC+4 and register-file read values
- `imm_in`  in  1  immediate-operand flag
- `shift_operand_in`  in  12  shifter operand field
- `signed_imm_24_in`  in  24  branch offset
- `dest_in`  in  4  destination register
- `status_in`  in  4  NZCV from the status register (C consumed by EX)
- `src1_in`, `src2_in`  in  4 each  source register numbers (present only with `ID_EX_SRC_FWD_EN`)
- Outputs: one `*_out` per `*_in` above, same width, registered
- `valid_out`  out  1  slot holds a real instruction
- `bubble_count`  out  `BUB_CNT_W`  saturating count of bubble/flush slots

## Operation
- Per-edge update priority (highest first):
  - **rst low:** all outputs are 0, including `valid_out` and `bubble_count`. Asynchronous: takes effect immediately and is held while low.
  - **freeze=1:** every register holds, including `valid_out` and `bubble_count`. `flush`/`bubble_in` are ignored this cycle. `flush` stays asserted by EX until the freeze drops, so it is not lost.
  - **flush=1 or bubble_in=1:** insert an empty slot.
    - Control outputs `wb_en`, `mem_r_en`, `mem_w_en`, `b`, `s` and `exe_cmd` load 0. `valid_out` loads 0.
    - Data fields load their inputs unchanged; they are don't-care for EX.
    - `bubble_count` increments by 1 if below all-ones and otherwise stays at all-ones. Flush and bubble together count once.
  - **otherwise:** all `*_out` load their `*_in`. `valid_out` loads 1.
- The control clear in this block is required even though the control unit already zeroes its outputs on `bubble_in`. A flush arrives from EX independently of the ID select.
- No combinational path from input to output; every output is a flop.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear at the outputs after edge N.
- Freeze of any length: the outputs are stable and identical to their values before the freeze. On the first edge after `freeze` falls, the normal priority resumes.
- Reset deasserted mid-stream: the first edge with `rst` high follows the normal rules. There is no extra empty cycle.
- Saturation: at all-ones, further bubbles leave `bubble_count` unchanged. There is no wrap to 0.

## Configuration
- `ID_EX_SRC_FWD_EN` defined:
  - `src1_in/out` and `src2_in/out` exist and are registered with the same priority rules as the other data fields.
  - They reset to 0.
  - They feed the EX forwarding unit.
- Undefined:
  - These four ports are absent.
  - The block has no source-register state.
  - All other behaviour is identical.

## Test plan
- Reset: drive all inputs to all-ones and pull `rst` low between edges → all outputs are 0 immediately. After `rst` rises, one edge → outputs equal the inputs and `valid_out`=1.
- Pass-through: `exe_cmd_in`=4'b0010, `pc_in`=32'h0000_0010, `dest_in`=4'd5, `wb_en_in`=1 → after 1 edge the outputs match exactly and `bubble_count` is unchanged.
- Freeze: hold `freeze`=1 for 3 edges while toggling every input, with `flush`=1 on the second edge → outputs stay at their pre-freeze values. When the freeze drops with `flush` still 1, the next edge gives control outputs 0, `valid_out`=0 and `bubble_count`+1.
- Flush and bubble together: `flush`=`bubble_in`=1 with `wb_en_in`=1, `mem_w_en_in`=1 → after 1 edge `wb_en_out`=`mem_w_en_out`=0, `exe_cmd_out`=0, `valid_out`=0, and `bubble_count` increments by exactly 1.
- Saturation: `BUB_CNT_W`=4, 17 consecutive bubble edges → `bubble_count` reads 15 after the 15th edge and stays 15.
- Macro on: `src1_in`=4'd3, `src2_in`=4'd7 → after 1 edge the outputs are 3 and 7. During a bubble they still load their inputs. Reset drives them to 0.
